spi_xfer_arbiter: RTL and testbench

Transaction controller that shares the single SPI shift engine between two requesters: the CPU coprocessor path (MTC0/MFC0 traffic) and a second master such as a DMA or boot loader. It grants one requester at a time with round-robin fairness, drives the engine's load/valid handshake, and waits for the received word with a bounded timeout. It returns the MISO word, or an error, to the granted requester. It sits between the SPI register file and the `spi` engine instance.

---
 rtl/spi_xfer_arbiter.sv | 147 ++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI shift engine between two requesters.
// Round-robin grant, engine load/valid handshake, bounded wait for the
// received word, and a one-cycle response (data or timeout error) back to
// whichever requester owns the current transfer.

`ifndef W_CPU
`define W_CPU 32
`endif

module spi_xfer_arbiter #(
    parameter int W_DATA  = `W_CPU,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              req0_valid_i,
    input  logic [W_DATA-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [W_DATA-1:0] req1_data_i,
    output logic              req1_ready_o,

    output logic              rsp0_valid_o,
    output logic              rsp1_valid_o,
    output logic [W_DATA-1:0] rsp_data_o,
    output logic              rsp_err_o,

    input  logic              eng_tx_ready_i,
    output logic [W_DATA-1:0] eng_tx_data_o,
    output logic              eng_tx_valid_o,
    input  logic [W_DATA-1:0] eng_rx_data_i,
    input  logic              eng_rx_valid_i,

    output logic              busy_o,
    output logic              err_sticky_o,
    input  logic              err_clr_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RX = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [W_DATA-1:0]   tx_buf_q;
    logic [W_DATA-1:0]   rx_buf_q;
    logic [CNT_W-1:0]    tout_cnt_q;
    logic [CNT_W-1:0]    tout_cnt_d;
    logic                err_flag_q;
    logic                err_sticky_q;

    logic                grant_valid;
    logic                grant_idx;
    logic                timeout_hit;

    // Grant decision: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant_valid = (state_q == IDLE) && (req0_valid_i || req1_valid_i);
        grant_idx   = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_idx = ~last_grant_q;
        end else if (req1_valid_i) begin
            grant_idx = 1'b1;
        end
        tout_cnt_d  = tout_cnt_q + 1'b1;
        timeout_hit = (state_q == WAIT_RX) && !eng_rx_valid_i && (tout_cnt_q == CNT_LAST);
    end

    // Ready is gated by reset so nothing is accepted while the block is held in reset
    assign req0_ready_o   = rst_ni && grant_valid && !grant_idx;
    assign req1_ready_o   = rst_ni && grant_valid &&  grant_idx;

    assign eng_tx_data_o  = tx_buf_q;
    assign eng_tx_valid_o = (state_q == ISSUE) && eng_tx_ready_i;

    assign rsp0_valid_o   = (state_q == RESP) && !owner_q;
    assign rsp1_valid_o   = (state_q == RESP) &&  owner_q;
    assign rsp_data_o     = rx_buf_q;
    assign rsp_err_o      = err_flag_q;
    assign busy_o         = (state_q != IDLE);
    assign err_sticky_o   = err_sticky_q;

    // Transfer FSM with its data buffers, timeout counter and error flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            tx_buf_q     <= '0;
            rx_buf_q     <= '0;
            tout_cnt_q   <= '0;
            err_flag_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        tx_buf_q     <= grant_idx ? req1_data_i : req0_data_i;
                        owner_q      <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_tx_valid_o) begin
                        tout_cnt_q <= '0;
                        state_q    <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    if (eng_rx_valid_i) begin
                        rx_buf_q   <= eng_rx_data_i;
                        err_flag_q <= 1'b0;
                        state_q    <= RESP;
                    end else if (timeout_hit) begin
                        rx_buf_q   <= '0;
                        err_flag_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        tout_cnt_q <= tout_cnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (timeout_hit) begin
                err_sticky_q <= 1'b1;
            end else if (err_clr_i) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter. A transaction-level reference
// model (who wins, when the response appears, what it carries) predicts
// every observed output cycle by cycle.

module tb_spi_xfer_arbiter;

    localparam int TOUT = 8;

    logic        clk;
    logic        rst_ni;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        eng_tx_ready;
    logic [31:0] eng_tx_data;
    logic        eng_tx_valid;
    logic [31:0] eng_rx_data;
    logic        eng_rx_valid;
    logic        busy;
    logic        err_sticky;
    logic        err_clr;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: who was served last, the sticky error, last response word
    int          lastGrant;
    bit          modelSticky;
    logic [31:0] lastRsp;

    spi_xfer_arbiter #(.W_DATA(32), .TIMEOUT(TOUT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req0_valid_i   (req0_valid),
        .req0_data_i    (req0_data),
        .req0_ready_o   (req0_ready),
        .req1_valid_i   (req1_valid),
        .req1_data_i    (req1_data),
        .req1_ready_o   (req1_ready),
        .rsp0_valid_o   (rsp0_valid),
        .rsp1_valid_o   (rsp1_valid),
        .rsp_data_o     (rsp_data),
        .rsp_err_o      (rsp_err),
        .eng_tx_ready_i (eng_tx_ready),
        .eng_tx_data_o  (eng_tx_data),
        .eng_tx_valid_o (eng_tx_valid),
        .eng_rx_data_i  (eng_rx_data),
        .eng_rx_valid_i (eng_rx_valid),
        .busy_o         (busy),
        .err_sticky_o   (err_sticky),
        .err_clr_i      (err_clr)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it, report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One full transaction: bp = cycles of engine backpressure, dly = WAIT_RX cycles before rx strobe
    task automatic applyStimulus(input bit v0, input bit v1, input logic [31:0] d0, input logic [31:0] d1,
                                 input int bp, input int dly, input logic [31:0] rxWord);
        int          winner;
        int          fireCyc;
        int          waitStart;
        int          rspCyc;
        logic [31:0] expData;
        bit          expErr;
        winner    = (v0 && v1) ? ((lastGrant == 1) ? 0 : 1) : (v1 ? 1 : 0);
        fireCyc   = 1 + bp;
        waitStart = 2 + bp;
        if (dly <= TOUT - 1) begin
            rspCyc  = waitStart + dly + 1;
            expData = rxWord;
            expErr  = 1'b0;
        end else begin
            rspCyc  = waitStart + TOUT;
            expData = 32'h0;
            expErr  = 1'b1;
        end

        @(posedge clk); #1;
        req0_valid   = v0;
        req0_data    = d0;
        req1_valid   = v1;
        req1_data    = d1;
        eng_tx_ready = (bp == 0);
        eng_rx_valid = 1'b0;
        err_clr      = 1'b0;
        @(negedge clk);
        checkOutput("req0_ready", {31'b0, req0_ready}, {31'b0, winner == 0});
        checkOutput("req1_ready", {31'b0, req1_ready}, {31'b0, winner == 1});
        checkOutput("busy_idle", {31'b0, busy}, 32'h0);
        lastGrant = winner;

        for (int c = 1; c <= rspCyc + 1; c++) begin
            @(posedge clk); #1;
            req0_valid   = v0 && (c <= rspCyc);
            req1_valid   = v1 && (c <= rspCyc);
            eng_tx_ready = (c >= fireCyc);
            eng_rx_valid = (c == waitStart + dly);
            eng_rx_data  = eng_rx_valid ? rxWord : $urandom;
            @(negedge clk);
            if (c == rspCyc && expErr) modelSticky = 1'b1;
            checkOutput("tx_valid", {31'b0, eng_tx_valid}, {31'b0, c == fireCyc});
            if (c == fireCyc)
                checkOutput("tx_data", eng_tx_data, (winner == 1) ? d1 : d0);
            checkOutput("busy", {31'b0, busy}, {31'b0, c <= rspCyc});
            checkOutput("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, (c == rspCyc) && (winner == 0)});
            checkOutput("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, (c == rspCyc) && (winner == 1)});
            if (c <= rspCyc) begin
                checkOutput("ready0_busy", {31'b0, req0_ready}, 32'h0);
                checkOutput("ready1_busy", {31'b0, req1_ready}, 32'h0);
            end
            if (c == rspCyc) begin
                checkOutput("rsp_data", rsp_data, expData);
                checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, expErr});
            end
            checkOutput("err_sticky", {31'b0, err_sticky}, {31'b0, modelSticky});
        end
        lastRsp      = expData;
        eng_rx_valid = 1'b0;
    endtask

    // Pulse err_clr for one cycle and confirm the sticky bit drops at the following edge
    task automatic clearErr();
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; eng_rx_valid = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        checkOutput("sticky_before_clr", {31'b0, err_sticky}, {31'b0, modelSticky});
        @(posedge clk); #1;
        err_clr     = 1'b0;
        modelSticky = 1'b0;
        @(negedge clk);
        checkOutput("sticky_after_clr", {31'b0, err_sticky}, 32'h0);
    endtask

    // Stray engine strobe while idle must be ignored completely
    task automatic strayStrobe();
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        eng_rx_valid = 1'b1;
        eng_rx_data  = $urandom;
        @(negedge clk);
        checkOutput("stray_busy0", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        eng_rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("stray_busy1", {31'b0, busy}, 32'h0);
        checkOutput("stray_rsp_data", rsp_data, lastRsp);
        checkOutput("stray_rsp0", {31'b0, rsp0_valid}, 32'h0);
    endtask

    // Check every output sits at its reset value
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, "_ready0"}, {31'b0, req0_ready}, 32'h0);
        checkOutput({tag, "_ready1"}, {31'b0, req1_ready}, 32'h0);
        checkOutput({tag, "_rsp0"}, {31'b0, rsp0_valid}, 32'h0);
        checkOutput({tag, "_rsp1"}, {31'b0, rsp1_valid}, 32'h0);
        checkOutput({tag, "_rsp_data"}, rsp_data, 32'h0);
        checkOutput({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
        checkOutput({tag, "_tx_valid"}, {31'b0, eng_tx_valid}, 32'h0);
        checkOutput({tag, "_tx_data"}, eng_tx_data, 32'h0);
        checkOutput({tag, "_sticky"}, {31'b0, err_sticky}, 32'h0);
    endtask

    // Start a requester-0 transfer, then pull reset while it waits for the engine
    task automatic resetDuringWait();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 32'h1234_5678; req1_valid = 1'b0;
        eng_tx_ready = 1'b1; eng_rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstw_ready0", {31'b0, req0_ready}, 32'h1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstw_fire", {31'b0, eng_tx_valid}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstw_busy", {31'b0, busy}, 32'h1);
        #2;
        rst_ni = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checkResetValues("rstw");
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("rstw_hold_rsp0", {31'b0, rsp0_valid}, 32'h0);
            checkOutput("rstw_hold_rsp1", {31'b0, rsp1_valid}, 32'h0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_ni = 1'b1;
        lastGrant   = 1;
        modelSticky = 1'b0;
        lastRsp     = 32'h0;
    endtask

    // Main sequence: reset, directed scenarios, then a randomized run
    initial begin
        rst_ni = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'hDEAD_0000; req1_data = 32'hBEEF_0000;
        eng_tx_ready = 1'b1; eng_rx_valid = 1'b0; eng_rx_data = 32'h0;
        err_clr = 1'b0;
        lastGrant = 1; modelSticky = 1'b0; lastRsp = 32'h0;
        #2;
        checkResetValues("reset");
        #10;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_ni = 1'b1;

        $display("[TB] round-robin with both requesters valid");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 32'h1000_0000 + i, 32'h2000_0000 + i, 0, 0, 32'h0000_0100 + i);

        $display("[TB] single request");
        applyStimulus(1'b1, 1'b0, 32'hA5A5_0001, 32'h0, 0, 0, 32'h0000_00C3);

        $display("[TB] engine backpressure");
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h5555_AAAA, 10, 2, 32'h0BAD_F00D);

        $display("[TB] timeout and sticky clear");
        applyStimulus(1'b1, 1'b0, 32'h7777_0001, 32'h0, 0, 20, 32'hFFFF_FFFF);
        clearErr();

        $display("[TB] rx strobe on timeout terminal count");
        applyStimulus(1'b1, 1'b0, 32'h7777_0002, 32'h0, 1, TOUT - 1, 32'h0000_5A5A);

        $display("[TB] stray rx strobe while idle");
        strayStrobe();

        $display("[TB] reset during WAIT_RX");
        resetDuringWait();
        applyStimulus(1'b1, 1'b1, 32'hC0DE_0000, 32'hC0DE_0001, 0, 1, 32'h0000_0042);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            bit v0, v1;
            int bp, dly;
            v0 = 1'($urandom % 2);
            v1 = 1'($urandom % 2);
            if (!v0 && !v1) v0 = 1'b1;
            bp  = ($urandom % 5 == 0) ? 10 : int'($urandom_range(0, 3));
            dly = int'($urandom_range(0, 11));
            applyStimulus(v0, v1, $urandom, $urandom, bp, dly, $urandom);
            if ($urandom % 4 == 0) strayStrobe();
            if (modelSticky && ($urandom % 2 == 0)) clearErr();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
